// File: rtl/parport_phy.sv
// Pad-side conditioning for the parallel printer port: input synchronisers and glitch filters,
// data-bus turnaround guard, and strobe stretching with data hold while a strobe is in flight.

module parport_filt #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic             clk32,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pad,
   output logic [WIDTH-1:0] filt
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] synced;
   logic [WIDTH-1:0] incoming;
   logic [CW-1:0]    cnt;

   assign synced   = sync_q[SYNC_STAGES-1];
   assign incoming = sync_q[SYNC_STAGES-2];

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: this flop chain is reset (unlike a RAM) so the idle pad level is
         // already in place and the first cycles after reset never report an edge.
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
         cnt  <= '0;
         filt <= '1;
      end else begin
         sync_q[0] <= pad;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         if (synced == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT_LEN - 1)) begin
            filt <= synced;
            cnt  <= '0;
         end else if (incoming != synced) begin
            // the synced value changes next cycle, so its stability count starts over
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

module parport_phy #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int TURN_CYCLES = 8,
   parameter int STB_MIN     = 16
) (
   input  logic       clk32,
   input  logic       reset_n,
   input  logic       core_strobe_oe,
   input  logic       core_strobe_out,
   output logic       core_strobe_in,
   input  logic       core_data_oe,
   input  logic [7:0] core_data_out,
   output logic [7:0] core_data_in,
   output logic       core_busy,
   input  logic       pin_strobe_i,
   output logic       pin_strobe_o,
   output logic       pin_strobe_oe,
   input  logic [7:0] pin_data_i,
   output logic [7:0] pin_data_o,
   output logic       pin_data_oe,
   input  logic       pin_busy_i,
   output logic       ack_pulse,
   output logic       turn_active
);

   localparam int TW = $clog2(TURN_CYCLES + 1);
   localparam int SW = $clog2(STB_MIN + 1);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_TURN = 2'd1;
   localparam logic [1:0] ST_ON   = 2'd2;

   // ---------------- pad inputs ----------------
   parport_filt #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_strobe (
      .clk32(clk32), .reset_n(reset_n), .pad(pin_strobe_i), .filt(core_strobe_in));

   parport_filt #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_busy (
      .clk32(clk32), .reset_n(reset_n), .pad(pin_busy_i), .filt(core_busy));

   parport_filt #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_data (
      .clk32(clk32), .reset_n(reset_n), .pad(pin_data_i), .filt(core_data_in));

   logic busy_d;

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         busy_d    <= 1'b1;
         ack_pulse <= 1'b0;
      end else begin
         busy_d    <= core_busy;
         ack_pulse <= busy_d & ~core_busy;
      end
   end

   // ---------------- data direction ----------------
   logic [1:0]    state, state_nx;
   logic [TW-1:0] turn_cnt, turn_cnt_nx;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_nx    = state;
      turn_cnt_nx = turn_cnt;
      case (state)
         ST_OFF: begin
            if (core_data_oe) begin
               state_nx    = ST_TURN;
               turn_cnt_nx = TW'(TURN_CYCLES);
            end
         end
         ST_TURN: begin
            if (!core_data_oe) begin
               state_nx    = ST_OFF;
               turn_cnt_nx = '0;
            end else begin
               if (turn_cnt != '0) turn_cnt_nx = turn_cnt - TW'(1);
               if (turn_cnt <= TW'(1)) state_nx = ST_ON;
            end
         end
         ST_ON: begin
            if (!core_data_oe) state_nx = ST_OFF;
         end
         default: begin
            state_nx    = ST_OFF;
            turn_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_OFF;
         turn_cnt    <= '0;
         pin_data_oe <= 1'b0;
         turn_active <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignment so every flop samples
         // the pre-edge values, independent of statement order.
         state       <= state_nx;
         turn_cnt    <= turn_cnt_nx;
         pin_data_oe <= (state_nx == ST_ON);
         turn_active <= (state_nx == ST_TURN);
      end
   end

   // ---------------- strobe and data hold ----------------
   logic          stb_d;
   logic          hold;
   logic [SW-1:0] stb_cnt;
   logic          stb_busy;
   logic          stb_start;

   assign stb_busy  = (stb_cnt > SW'(1));
   assign stb_start = core_strobe_oe & pin_strobe_oe & stb_d & ~core_strobe_out & ~stb_busy;

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         stb_d         <= 1'b1;
         hold          <= 1'b0;
         stb_cnt       <= '0;
         pin_strobe_oe <= 1'b0;
         pin_strobe_o  <= 1'b1;
         pin_data_o    <= 8'hFF;
      end else begin
         stb_d         <= core_strobe_out;
         pin_strobe_oe <= core_strobe_oe;

         // hold keeps the byte the printer is latching until strobe has been seen high
         if (!(hold && core_strobe_oe && !stb_start)) pin_data_o <= core_data_out;

         if (!core_strobe_oe) begin
            stb_cnt      <= '0;
            pin_strobe_o <= 1'b1;
            hold         <= 1'b0;
         end else if (stb_busy) begin
            stb_cnt <= stb_cnt - SW'(1);
         end else if (stb_start) begin
            stb_cnt      <= SW'(STB_MIN);
            pin_strobe_o <= 1'b0;
            hold         <= 1'b1;
         end else begin
            stb_cnt      <= '0;
            pin_strobe_o <= core_strobe_out;
            if (core_strobe_out) hold <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_parport_phy.sv
// Bench for parport_phy: a history-based model checked every cycle, plus directed
// scenarios with hand-computed timing expectations.

module tb_parport_phy;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int S = 2;
   localparam int F = 4;
   localparam int T = 8;
   localparam int M = 16;

   logic       clk32   = 1'b0;
   logic       reset_n = 1'b0;
   logic       core_strobe_oe  = 1'b0;
   logic       core_strobe_out = 1'b1;
   logic       core_data_oe    = 1'b0;
   logic [7:0] core_data_out   = 8'hFF;
   logic       pin_strobe_i    = 1'b1;
   logic [7:0] pin_data_i      = 8'hFF;
   logic       pin_busy_i      = 1'b1;
   logic       core_strobe_in, core_busy, pin_strobe_o, pin_strobe_oe;
   logic       pin_data_oe, ack_pulse, turn_active;
   logic [7:0] core_data_in, pin_data_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   parport_phy #(.SYNC_STAGES(S), .FILT_LEN(F), .TURN_CYCLES(T), .STB_MIN(M)) dut (
      .clk32(clk32), .reset_n(reset_n),
      .core_strobe_oe(core_strobe_oe), .core_strobe_out(core_strobe_out),
      .core_strobe_in(core_strobe_in), .core_data_oe(core_data_oe),
      .core_data_out(core_data_out), .core_data_in(core_data_in), .core_busy(core_busy),
      .pin_strobe_i(pin_strobe_i), .pin_strobe_o(pin_strobe_o), .pin_strobe_oe(pin_strobe_oe),
      .pin_data_i(pin_data_i), .pin_data_o(pin_data_o), .pin_data_oe(pin_data_oe),
      .pin_busy_i(pin_busy_i), .ack_pulse(ack_pulse), .turn_active(turn_active));

   always #5 clk32 = ~clk32;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk32);
   endtask

   // ---------------- model ----------------
   // History index k holds the pad value sampled k edges ago; a value is accepted once it
   // occupied the F samples that have fully crossed the S-stage synchroniser.
   logic [S+F-1:0] h_stb, h_busy;
   logic [7:0]     h_data [S+F];
   logic       m_stb_in, m_busy, m_busy_prev, m_ack, m_turn, m_doe, m_soe, m_so, prev_so, episode;
   logic [7:0] m_data_in, m_do;
   int         edge_n, win_end, oe_run;

   function automatic logic filt1(input logic [S+F-1:0] h, input logic cur);
      for (int k = S + 1; k < S + F; k++) if (h[k] !== h[S]) return cur;
      return h[S];
   endfunction

   always @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         h_stb = '1; h_busy = '1;
         for (int k = 0; k < S + F; k++) h_data[k] = 8'hFF;
         m_stb_in = 1'b1; m_busy = 1'b1; m_busy_prev = 1'b1; m_data_in = 8'hFF;
         m_ack = 1'b0; m_turn = 1'b0; m_doe = 1'b0; m_soe = 1'b0; m_so = 1'b1;
         m_do = 8'hFF; prev_so = 1'b1; episode = 1'b0;
         edge_n = 0; win_end = 0; oe_run = 0;
      end else begin
         bit data_stable;
         bit fall;
         edge_n++;
         m_ack       = m_busy_prev & ~m_busy;
         m_busy_prev = m_busy;

         h_stb  = {h_stb[S+F-2:0], pin_strobe_i};
         h_busy = {h_busy[S+F-2:0], pin_busy_i};
         for (int k = S + F - 1; k > 0; k--) h_data[k] = h_data[k-1];
         h_data[0] = pin_data_i;
         m_stb_in = filt1(h_stb, m_stb_in);
         m_busy   = filt1(h_busy, m_busy);
         data_stable = 1'b1;
         for (int k = S + 1; k < S + F; k++) if (h_data[k] !== h_data[S]) data_stable = 1'b0;
         if (data_stable) m_data_in = h_data[S];

         oe_run = core_data_oe ? ((oe_run < 1000) ? oe_run + 1 : oe_run) : 0;
         m_turn = (oe_run >= 1) && (oe_run <= T);
         m_doe  = (oe_run > T);

         fall = m_soe && prev_so && !core_strobe_out;
         if (!core_strobe_oe) begin
            win_end = 0; m_so = 1'b1; episode = 1'b0; m_do = core_data_out;
         end else if (edge_n < win_end) begin
            m_so = 1'b0;
         end else if (fall) begin
            win_end = edge_n + M; m_so = 1'b0; episode = 1'b1; m_do = core_data_out;
         end else begin
            m_so = core_strobe_out;
            if (!episode) m_do = core_data_out;
            if (core_strobe_out) episode = 1'b0;
         end
         m_soe   = core_strobe_oe;
         prev_so = core_strobe_out;
      end
   end

   always @(negedge clk32) begin
      if (chk_en) begin
         check("core_strobe_in", core_strobe_in, m_stb_in);
         check("core_busy", core_busy, m_busy);
         check("core_data_in", core_data_in, m_data_in);
         check("ack_pulse", ack_pulse, m_ack);
         check("turn_active", turn_active, m_turn);
         check("pin_data_oe", pin_data_oe, m_doe);
         check("pin_strobe_oe", pin_strobe_oe, m_soe);
         check("pin_strobe_o", pin_strobe_o, m_so);
         check("pin_data_o", pin_data_o, m_do);
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int first, cnt, low, rise_i;
      bit flag;

      tick(3);
      check("rst_strobe_in", core_strobe_in, 1'b1);
      check("rst_busy", core_busy, 1'b1);
      check("rst_data_in", core_data_in, 8'hFF);
      check("rst_pin_data", pin_data_o, 8'hFF);
      check("rst_pin_strobe", pin_strobe_o, 1'b1);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // data pad filter: glitch byte never reaches the core
      pin_data_i = 8'h3C; tick(8);
      check("data_filt_3c", core_data_in, 8'h3C);
      pin_data_i = 8'h12; tick(2);
      pin_data_i = 8'h34; flag = 1'b0; first = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk32);
         if (core_data_in === 8'h12) flag = 1'b1;
         if (core_data_in === 8'h34 && first == 0) first = i;
      end
      check("data_glitch_seen", flag, 1'b0);
      check("data_latency", first, 6);
      pin_strobe_i = 1'b0; tick(5); pin_strobe_i = 1'b1; tick(8);

      // busy filter: short pulse rejected, long pulse accepted with one ack
      pin_busy_i = 1'b0; tick(3); pin_busy_i = 1'b1;
      flag = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk32);
         if (core_busy !== 1'b1 || ack_pulse !== 1'b0) flag = 1'b1;
      end
      check("busy_short_reject", flag, 1'b0);
      pin_busy_i = 1'b0; first = 0; cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk32);
         if (core_busy === 1'b0 && first == 0) first = i;
         if (ack_pulse === 1'b1) cnt++;
         if (i == 10) pin_busy_i = 1'b1;
      end
      check("busy_latency", first, 6);
      check("ack_count", cnt, 1);

      // turnaround
      core_data_oe = 1'b1; first = 0; cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk32);
         if (turn_active === 1'b1) cnt++;
         if (pin_data_oe === 1'b1 && first == 0) first = i;
      end
      check("turn_cycles", cnt, 8);
      check("turn_oe_cycle", first, 9);
      core_data_oe = 1'b0; tick(1);
      check("oe_release", pin_data_oe, 1'b0);
      tick(3);
      core_data_oe = 1'b1; tick(3); core_data_oe = 1'b0; flag = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk32);
         if (pin_data_oe === 1'b1) flag = 1'b1;
      end
      check("turn_abort", flag, 1'b0);

      // short strobe stretched, mid-stretch re-fall ignored
      core_strobe_oe = 1'b1; tick(3);
      core_data_out = 8'h5A; core_strobe_out = 1'b0; low = 0; rise_i = 0; flag = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk32);
         if (pin_strobe_o === 1'b0) begin
            low++;
            if (pin_data_o !== 8'h5A) flag = 1'b1;
         end else if (rise_i == 0 && low > 0) rise_i = i;
         if (rise_i != 0 && i == rise_i + 1) check("stretch_release_data", pin_data_o, 8'hA5);
         if (i == 2) begin core_strobe_out = 1'b1; core_data_out = 8'hA5; end
         if (i == 5) core_strobe_out = 1'b0;
         if (i == 7) core_strobe_out = 1'b1;
      end
      check("stretch_low", low, 16);
      check("stretch_rise", rise_i, 17);
      check("stretch_freeze", flag, 1'b0);

      // long strobe
      core_data_out = 8'h3C; core_strobe_out = 1'b0; low = 0; rise_i = 0; flag = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk32);
         if (pin_strobe_o === 1'b0) begin
            low++;
            if (pin_data_o !== 8'h3C) flag = 1'b1;
         end else if (rise_i == 0 && low > 0) rise_i = i;
         if (rise_i != 0 && i == rise_i + 1) check("long_release_data", pin_data_o, 8'h99);
         if (i == 20) core_data_out = 8'h99;
         if (i == 40) core_strobe_out = 1'b1;
      end
      check("long_low", low, 40);
      check("long_rise", rise_i, 41);
      check("long_freeze", flag, 1'b0);

      // cancel mid-stretch
      core_data_out = 8'h11; core_strobe_out = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk32);
         if (i == 3) core_data_out = 8'h22;
         if (i == 5) core_strobe_oe = 1'b0;
      end
      @(negedge clk32);
      check("cancel_oe", pin_strobe_oe, 1'b0);
      check("cancel_strobe", pin_strobe_o, 1'b1);
      check("cancel_data", pin_data_o, 8'h22);
      core_strobe_out = 1'b1; tick(1);
      core_strobe_oe = 1'b1; tick(3);

      // data-oe drop coincident with strobe fall
      core_data_oe = 1'b1; tick(12);
      core_data_oe = 1'b0; core_data_out = 8'h6D; core_strobe_out = 1'b0; tick(2);
      core_strobe_out = 1'b1; tick(20);

      // async reset mid-stretch with data bus driven
      core_data_oe = 1'b1; tick(12);
      core_data_out = 8'h77; core_strobe_out = 1'b0; tick(5);
      #2 reset_n = 1'b0;
      #1;
      check("areset_strobe", pin_strobe_o, 1'b1);
      check("areset_strobe_oe", pin_strobe_oe, 1'b0);
      check("areset_data", pin_data_o, 8'hFF);
      check("areset_data_oe", pin_data_oe, 1'b0);
      check("areset_turn", turn_active, 1'b0);
      core_strobe_out = 1'b1; core_strobe_oe = 1'b0; core_data_oe = 1'b0; core_data_out = 8'hFF;
      tick(2);
      reset_n = 1'b1;
      tick(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
